// File: rtl/tmp_conv_sched_pkg.sv
// Shared types and default constants for the temperature-sensor conversion scheduler.
package tmp_pkg;

  localparam int unsigned RST_CYC_D    = 4;
  localparam int unsigned SETTLE_SMP_D = 8;
  localparam int unsigned WIN_LOG2_D   = 8;
  localparam int unsigned PERIOD_W_D   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    SETTLE,
    MEAS,
    DONE,
    INTERVAL
  } tmp_state_e;

endpackage

// File: rtl/tmp_conv_sched_if.sv
// Result port between the conversion scheduler and the readout block.
interface tmp_conv_sched_if
  import tmp_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_D
) ();

  logic [WIN_LOG2:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );

endinterface

// File: rtl/tmp_conv_sched_evt_sync.sv
// Brings the core's toggle strobe and comparator bit into the clk domain.
module tmp_evt_sync
  import tmp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_smp,
  input  logic i_cmp,
  output logic o_evt,
  output logic o_bit
);

  logic [2:0] r_smp;
  logic [1:0] r_cmp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp <= '0;
      r_cmp <= '0;
    end else begin
      r_smp <= {r_smp[1:0], i_smp};
      r_cmp <= {r_cmp[0], i_cmp};
    end
  end

  // Either edge of the strobe is one decision.
  assign o_evt = r_smp[2] ^ r_smp[1];
  assign o_bit = r_cmp[1];

endmodule

// File: rtl/tmp_conv_sched.sv
// Conversion scheduler: resets the sensor core, skips settling decisions, counts ones over a window.
module tmp_conv_sched
  import tmp_pkg::*;
#(
  parameter int unsigned RST_CYC    = RST_CYC_D,
  parameter int unsigned SETTLE_SMP = SETTLE_SMP_D,
  parameter int unsigned WIN_LOG2   = WIN_LOG2_D,
  parameter int unsigned PERIOD_W   = PERIOD_W_D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                core_rst,
  input  logic                core_smp,
  input  logic                core_cmp,
  tmp_conv_sched_if.master    res,
  output logic                busy,
  output logic                ovr,
  input  logic                ovr_clr
);

  localparam int unsigned          CYC_W     = (PERIOD_W > 4) ? PERIOD_W : 4;
  localparam logic [CYC_W-1:0]     WAKE_LAST = CYC_W'(RST_CYC - 1);
  localparam logic [7:0]           SET_LAST  = 8'(SETTLE_SMP - 1);
  localparam logic [WIN_LOG2:0]    WIN_LAST  = {1'b0, {WIN_LOG2{1'b1}}};

  tmp_state_e          r_state;
  tmp_state_e          w_state_nx;
  logic [CYC_W-1:0]    r_cyc;
  logic [PERIOD_W-1:0] r_per;
  logic [7:0]          r_set;
  logic [WIN_LOG2:0]   r_nsmp;
  logic [WIN_LOG2:0]   r_ones;
  logic [WIN_LOG2:0]   r_data;
  logic                r_valid;
  logic                r_ovr;

  logic                w_evt;
  logic                w_bit;
  logic                w_wake_end;
  logic                w_int_end;
  logic                w_set_end;
  logic                w_win_end;
  logic                w_drop;
  logic [CYC_W-1:0]    w_per_last;

  tmp_evt_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_smp (core_smp),
    .i_cmp (core_cmp),
    .o_evt (w_evt),
    .o_bit (w_bit)
  );

  assign w_per_last = CYC_W'(r_per) - CYC_W'(1);
  assign w_wake_end = (r_cyc == WAKE_LAST);
  assign w_int_end  = (r_cyc == w_per_last);
  assign w_set_end  = (r_set == SET_LAST);
  assign w_win_end  = (r_nsmp == WIN_LAST);
  assign w_drop     = (r_state == DONE) && r_valid && !res.res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (r_state != IDLE && !en) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (en) w_state_nx = WAKE;
        WAKE:     if (w_wake_end) w_state_nx = (SETTLE_SMP == 0) ? MEAS : SETTLE;
        SETTLE:   if (w_evt && w_set_end) w_state_nx = MEAS;
        MEAS:     if (w_evt && w_win_end) w_state_nx = DONE;
        DONE:     w_state_nx = (period == '0) ? WAKE : INTERVAL;
        INTERVAL: if (w_int_end) w_state_nx = WAKE;
        default:  w_state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    core_rst = 1'b1;
    busy     = 1'b1;
    case (r_state)
      IDLE:               busy     = 1'b0;
      SETTLE, MEAS, DONE: core_rst = 1'b0;
      default:            core_rst = 1'b1;
    endcase
  end

  // Cycle counter restarts on every state change, so it serves both WAKE and INTERVAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc  <= '0;
      r_per  <= '0;
      r_set  <= '0;
      r_nsmp <= '0;
      r_ones <= '0;
    end else begin
      if (w_state_nx != r_state) begin
        r_cyc <= '0;
      end else if (r_state == WAKE || r_state == INTERVAL) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end

      if (r_state == DONE) begin
        r_per <= period;
      end

      if (w_state_nx == WAKE && r_state != WAKE) begin
        r_set  <= '0;
        r_nsmp <= '0;
        r_ones <= '0;
      end else if (w_evt && r_state == SETTLE) begin
        r_set <= r_set + 8'd1;
      end else if (w_evt && r_state == MEAS) begin
        r_nsmp <= r_nsmp + (WIN_LOG2 + 1)'(1);
        r_ones <= r_ones + {{WIN_LOG2{1'b0}}, w_bit};
      end
    end
  end

  // DONE reloads even when the held result is being taken in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_state == DONE && (!r_valid || res.res_ready)) begin
        r_data  <= r_ones;
        r_valid <= 1'b1;
      end else if (r_valid && res.res_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign res.res_data  = r_data;
  assign res.res_valid = r_valid;
  assign ovr           = r_ovr;

endmodule

// File: tb/tb_tmp_conv_sched.sv
// Randomized bench for tmp_conv_sched: a behavioural core emits decisions, a scoreboard checks results.
module tb_tmp_conv_sched;

  localparam int unsigned RST_CYC    = 4;
  localparam int unsigned SETTLE_SMP = 2;
  localparam int unsigned WIN_LOG2   = 4;
  localparam int unsigned PERIOD_W   = 16;
  localparam int unsigned NDEC       = SETTLE_SMP + (1 << WIN_LOG2);

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic [PERIOD_W-1:0] period;
  logic                core_rst;
  logic                core_smp;
  logic                core_cmp;
  logic                busy;
  logic                ovr;
  logic                ovr_clr;

  tmp_conv_sched_if #(.WIN_LOG2(WIN_LOG2)) res_if ();

  tmp_conv_sched #(
    .RST_CYC    (RST_CYC),
    .SETTLE_SMP (SETTLE_SMP),
    .WIN_LOG2   (WIN_LOG2),
    .PERIOD_W   (PERIOD_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .period   (period),
    .core_rst (core_rst),
    .core_smp (core_smp),
    .core_cmp (core_cmp),
    .res      (res_if),
    .busy     (busy),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned acc = 0;
  int unsigned cyc = 0;
  int unsigned feeds_done = 0;
  int unsigned fed = 0;
  int unsigned last_k = 0;
  int unsigned mode = 0;
  int unsigned gmin = 2;
  int unsigned gmax = 5;
  int          exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expected window count.
  always @(negedge clk) begin
    if (!reset && res_if.res_valid && res_if.res_ready) begin
      if (exp_q.size() == 0) chk("res_unexp", 32'(res_if.res_valid), 32'd0);
      else chk("res_data", 32'(res_if.res_data), 32'(exp_q.pop_front()));
      acc++;
    end
  end

  function automatic bit pick(input int unsigned i);
    case (mode)
      0:       return (i >= SETTLE_SMP) && (((i - SETTLE_SMP) % 2) == 0);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // Sensor core: once released, emits exactly NDEC decisions; expected = ones after the settle ones.
  initial begin : core_model
    int unsigned sum;
    bit          ok;
    bit          b;
    core_smp = 1'b0;
    core_cmp = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && core_rst === 1'b0) begin
        sum = 0;
        ok  = 1'b1;
        fed = 0;
        for (int unsigned i = 0; i < NDEC; i++) begin
          repeat ($urandom_range(gmax, gmin)) @(posedge clk);
          #1;
          if (core_rst !== 1'b0) begin
            ok = 1'b0;
            break;
          end
          b        = pick(i);
          core_cmp = b;
          core_smp = ~core_smp;
          if (i >= SETTLE_SMP) sum += 32'(b);
          fed++;
          last_k = cyc;
        end
        if (ok) begin
          exp_q.push_back(int'(sum));
          feeds_done++;
        end
        while (core_rst === 1'b0 && !reset) @(negedge clk);
      end
    end
  end

  task automatic wait_results(input int unsigned n);
    int unsigned tgt;
    int unsigned t;
    tgt = acc + n;
    t   = 0;
    while (acc < tgt && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (acc < tgt) chk("tmo_res", acc, tgt);
  endtask

  task automatic wait_feeds(input int unsigned tgt);
    int unsigned t;
    t = 0;
    while (feeds_done < tgt && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (feeds_done < tgt) chk("tmo_feed", feeds_done, tgt);
  endtask

  task automatic count_hi(output int unsigned cnt);
    cnt = 0;
    while (core_rst === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic stop_conv();
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("stop_idle", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned cnt;
    int unsigned base;
    int unsigned t;
    reset            = 1'b1;
    en               = 1'b0;
    period           = '0;
    ovr_clr          = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_valid", 32'(res_if.res_valid), 32'd0);
    chk("rst_data", 32'(res_if.res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fixed pattern, back-to-back conversions.
    mode = 0;
    en   = 1'b1;
    cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && core_rst) cnt++;
      else if (busy && !core_rst) break;
    end
    chk("wake_len", cnt, RST_CYC);
    wait_results(1);
    count_hi(cnt);
    chk("gap_p0", cnt, RST_CYC);
    stop_conv();

    // Full scale, zero scale, then random windows.
    mode = 1;
    en   = 1'b1;
    wait_results(1);
    mode = 2;
    wait_results(1);
    mode = 3;
    wait_results(3);
    stop_conv();

    // Idle period between conversions.
    period = PERIOD_W'(10);
    en     = 1'b1;
    wait_results(1);
    count_hi(cnt);
    chk("gap_p10", cnt, 10 + RST_CYC);
    wait_results(1);
    stop_conv();
    period = '0;

    // Consumer stalls: first result held, second dropped, third loads on a DONE-cycle accept.
    res_if.res_ready = 1'b0;
    base = feeds_done;
    en   = 1'b1;
    wait_feeds(base + 1);
    repeat (6) @(negedge clk);
    #1;
    chk("hold1_valid", 32'(res_if.res_valid), 32'd1);
    chk("hold1_data", 32'(res_if.res_data), 32'(exp_q[0]));
    chk("hold1_ovr", 32'(ovr), 32'd0);
    wait_feeds(base + 2);
    repeat (6) @(negedge clk);
    #1;
    chk("hold2_data", 32'(res_if.res_data), 32'(exp_q[0]));
    chk("drop_ovr", 32'(ovr), 32'd1);
    if (exp_q.size() > 1) exp_q.delete(1);
    @(posedge clk);
    #1;
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr), 32'd0);
    wait_feeds(base + 3);
    t = 0;
    while (cyc != last_k + 3 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    res_if.res_ready = 1'b1;
    wait_results(2);
    chk("reload_ovr", 32'(ovr), 32'd0);
    stop_conv();

    // Enable dropped mid-window: partial count discarded.
    gmin = 10;
    gmax = 10;
    fed  = 0;
    en   = 1'b1;
    t    = 0;
    while (fed < 5 && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("fed5", fed, 5);
    repeat (4) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    repeat (20) @(negedge clk);
    chk("abort_valid", 32'(res_if.res_valid), 32'd0);
    chk("abort_noexp", exp_q.size(), 0);
    gmin = 2;
    gmax = 5;
    en   = 1'b1;
    wait_results(1);
    stop_conv();

    // Asynchronous reset in SETTLE with a result pending.
    res_if.res_ready = 1'b0;
    base = feeds_done;
    en   = 1'b1;
    wait_feeds(base + 1);
    t = 0;
    while (fed != 1 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("pre_valid", 32'(res_if.res_valid), 32'd1);
    chk("pre_settle", 32'(core_rst), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_core_rst", 32'(core_rst), 32'd1);
    chk("arst_valid", 32'(res_if.res_valid), 32'd0);
    chk("arst_data", 32'(res_if.res_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ovr", 32'(ovr), 32'd0);
    exp_q.delete();
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/tmp_conv_sched.md
Name: tmp_conv_sched

Overview:
- Conversion scheduler for the temperature-sensor digital core.
- Puts the core through periodic conversions:
  - holds the core in reset, then releases it;
  - discards the settling decisions;
  - counts comparator-high decisions over a fixed window of decisions.
- Presents each count as a result on a valid/ready port for the readout logic.
- Sits between the sensor core and the register/readout block.

Parameters:
- RST_CYC, 4, cycles core_rst is held high at the start of each conversion (1..15)
- SETTLE_SMP, 8, decision strobes discarded after core release (0..255)
- WIN_LOG2, 8, window length is 2^WIN_LOG2 decision strobes
- PERIOD_W, 16, width of the inter-conversion idle counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- en  in  1  enable; high = run conversions back to back, separated by period
- period  in  PERIOD_W  idle cycles between the end of one conversion and the next core reset; 0 = none
- core_rst  out  1  reset to the sensor core
- core_smp  in  1  decision strobe from the core, asynchronous to clk, level-toggle per decision
- core_cmp  in  1  comparator decision from the core, asynchronous
- res_data  out  WIN_LOG2+1  ones count of the last completed window
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- busy  out  1  state other than IDLE
- ovr  out  1  sticky: a result was dropped
- ovr_clr  in  1  clears ovr

Behaviour:
- Reset values: core_rst=1, res_data=0, res_valid=0, busy=0, ovr=0; state=IDLE; all counters=0.
- Input synchronisation:
  - core_smp and core_cmp each pass through a 2-flop synchroniser.
  - A decision event is any edge of the synchronised core_smp, detected with a third flop.
  - The event samples the synchronised core_cmp in the same cycle.
  - Event latency is 3 clk from the core_smp toggle.
- States:
  - IDLE:
    - core_rst=1.
    - If en=1, go to WAKE next cycle with the cycle counter cleared.
  - WAKE:
    - core_rst=1 for exactly RST_CYC cycles, then go to SETTLE.
    - Clear the sample counter and ones counter on entry.
  - SETTLE:
    - core_rst=0.
    - Count decision events; after SETTLE_SMP events go to MEAS.
    - If SETTLE_SMP=0, go straight to MEAS.
  - MEAS:
    - core_rst=0.
    - Each event increments the sample counter and adds the cmp bit to the ones counter.
    - On the event that completes 2^WIN_LOG2 samples, that event is included and the next state is DONE.
  - DONE (exactly 1 cycle):
    - Publish the ones count, which ranges 0..2^WIN_LOG2 inclusive, hence width WIN_LOG2+1.
    - Go to INTERVAL.
  - INTERVAL:
    - core_rst=1.
    - Count period cycles, then go to WAKE.
    - If period=0, go straight from DONE to WAKE.
    - period is sampled on entry to INTERVAL.
- Result handshake:
  - In DONE, if res_valid=0, or res_valid=1 with res_ready=1 in the same cycle:
    - load res_data;
    - res_valid=1.
  - Otherwise the new result is dropped and ovr is set.
  - res_valid clears on the cycle after res_valid&res_ready, unless a DONE reload happens in that same cycle.
  - res_data is stable while res_valid=1 and res_ready=0.
- ovr:
  - Set has priority over ovr_clr in the same cycle.
- en deasserted in any state except IDLE:
  - next state is IDLE;
  - core_rst=1 on the next cycle;
  - partial counts are discarded;
  - a pending result and ovr are kept.
- en deasserted in DONE: the result is still published.
- Counters saturate nowhere; all widths are sized so overflow is impossible.
- Asynchronous reset mid-conversion: everything returns immediately to reset values, including dropping any pending result.

Decomposition:
- Shared package tmp_pkg:
  - state enum (IDLE, WAKE, SETTLE, MEAS, DONE, INTERVAL);
  - default parameter constants.
- One sub-module, tmp_evt_sync:
  - 2-flop synchroniser on smp and cmp, plus toggle-edge detect;
  - outputs: evt (1-cycle pulse) and bit.
- Remainder is a single FSM with counters.

Test Plan:
- Scenario 1: reset, en=1, period=0, WIN_LOG2=4, SETTLE_SMP=2, feed 18 events with cmp pattern 0,0 then 1,0 repeating.
  - core_rst is high exactly 4 cycles.
  - res_valid rises with res_data=8.
  - The two settle decisions are not counted.
- Scenario 2: window with all cmp=1 (WIN_LOG2=4) -> res_data=16 (full-scale, MSB set). Window with all cmp=0 -> res_data=0.
- Scenario 3: res_ready held 0 across two conversions.
  - The first result is held unchanged.
  - ovr=1 after the second DONE.
  - ovr_clr pulse -> ovr=0.
  - res_ready=1 in the DONE cycle of the third conversion -> third result loads, ovr stays 0.
- Scenario 4: period=10.
  - Exactly 10 cycles elapse from the DONE cycle to the first WAKE cycle.
  - core_rst stays high throughout INTERVAL and WAKE, i.e. 10+4 cycles.
- Scenario 5: en dropped mid-MEAS after 5 events.
  - IDLE next cycle, busy=0, core_rst=1.
  - No result is published.
  - Re-enable -> a fresh conversion counts from 0.
- Scenario 6: reset asserted asynchronously mid-SETTLE with res_valid=1 -> all outputs go to reset values without waiting for a clk edge.
